mas_alu_dispatch: RTL and testbench

- Upstream issue stage for the MAS ALU functional units (add, sub, logic, left shift, right shift).
- Accepts one operation request over a valid/ready handshake and drives a shared registered operand bus into all units.
- Waits the fixed unit latency, selects the addressed unit's registered result, and returns it over a valid/ready response handshake.
- One operation in flight at a time.

---
 rtl/mas_alu_dispatch_pkg.sv | 32 +++
 rtl/mas_alu_dispatch_if.sv | 48 ++++
 rtl/mas_alu_dispatch.sv | 116 +++++++++++
 tb/tb_mas_alu_dispatch.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mas_alu_dispatch_pkg.sv
// Shared types and constants for the MAS ALU dispatch block and its functional units.
`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

package mas_alu_pkg;

  typedef enum logic [2:0] {
    MAS_OP_ADD = 3'd0,
    MAS_OP_SUB = 3'd1,
    MAS_OP_AND = 3'd2,
    MAS_OP_OR  = 3'd3,
    MAS_OP_XOR = 3'd4,
    MAS_OP_SLL = 3'd5,
    MAS_OP_SRL = 3'd6
  } mas_alu_opc_e;

  localparam int MAS_NUM_FU     = 7;
  localparam int MAS_FU_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mas_dispatch_state_e;

  // Unit index equals opcode value, so legality is simply "a unit exists at that index".
  function automatic logic mas_opc_legal(input logic [2:0] opc, input int num_fu);
    return int'(opc) < num_fu;
  endfunction

endpackage

// File: rtl/mas_alu_dispatch_if.sv
// Request, response and functional-unit operand/result signals of the dispatch block.
`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

interface mas_alu_dispatch_if
  import mas_alu_pkg::*;
#(
  parameter int BLEN   = `MAS_BLEN,
  parameter int NUM_FU = MAS_NUM_FU
);

  logic                   req_valid;
  logic                   req_ready;
  // Plain 3-bit vector rather than mas_alu_opc_e so the illegal code 7 can be carried.
  logic [2:0]             req_opc;
  logic [BLEN-1:0]        req_op1;
  logic [BLEN-1:0]        req_op2;

  logic [BLEN-1:0]        fu_op1;
  logic [BLEN-1:0]        fu_op2;
  logic [NUM_FU-1:0]      fu_ready;
  logic [NUM_FU*BLEN-1:0] fu_res;

  logic                   resp_valid;
  logic                   resp_ready;
  logic [BLEN-1:0]        resp_data;
  logic                   resp_err;

  modport slave (
    input  req_valid, req_opc, req_op1, req_op2,
    output req_ready,
    output fu_op1, fu_op2,
    input  fu_ready, fu_res,
    output resp_valid, resp_data, resp_err,
    input  resp_ready
  );

  modport master (
    output req_valid, req_opc, req_op1, req_op2,
    input  req_ready,
    input  fu_op1, fu_op2,
    output fu_ready, fu_res,
    input  resp_valid, resp_data, resp_err,
    output resp_ready
  );

endinterface

// File: rtl/mas_alu_dispatch.sv
// Issue stage for the MAS ALU units: one op in flight, shared registered operand bus,
// fixed-latency wait, result capture from the addressed unit, valid/ready response.
`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

module mas_alu_dispatch
  import mas_alu_pkg::*;
#(
  parameter int BLEN   = `MAS_BLEN,
  parameter int NUM_FU = MAS_NUM_FU,
  parameter int FU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  mas_alu_dispatch_if.slave  bus
);

  localparam int         SEL_W = ($clog2(NUM_FU) > 3) ? $clog2(NUM_FU) : 3;
  localparam logic [3:0] LAT_C = 4'(FU_LAT);

  mas_dispatch_state_e state_q;
  logic [3:0]          cnt_q;
  logic [SEL_W-1:0]    sel_q;
  logic [BLEN-1:0]     fu_op1_q;
  logic [BLEN-1:0]     fu_op2_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [BLEN-1:0]     resp_data_q;

  logic [BLEN-1:0]     sel_res;
  logic                sel_rdy;
  logic                cnt_done;
  logic                opc_legal;

  // Result/ready mux over the addressed unit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    sel_res = '0;
    sel_rdy = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_res = bus.fu_res[i*BLEN +: BLEN];
        sel_rdy = bus.fu_ready[i];
      end
    end
  end

  assign cnt_done  = (cnt_q == LAT_C);
  assign opc_legal = mas_opc_legal(bus.req_opc, NUM_FU);

  // NOTE: all state below is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      fu_op1_q     <= '0;
      fu_op2_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (opc_legal) begin
              fu_op1_q <= bus.req_op1;
              fu_op2_q <= bus.req_op2;
              sel_q    <= SEL_W'(bus.req_opc);
              cnt_q    <= '0;
              state_q  <= WAIT;
            end else begin
              // Illegal opcode: answer straight away, leave the operand bus untouched.
              resp_data_q  <= '0;
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end
          end
        end

        WAIT: begin
          if (!cnt_done) begin
            cnt_q <= cnt_q + 4'd1;
          end
          if (cnt_done && sel_rdy) begin
            resp_data_q  <= sel_res;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end

        RESP: begin
          // resp_data is deliberately kept after the handshake.
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            state_q      <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.fu_op1     = fu_op1_q;
  assign bus.fu_op2     = fu_op2_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_mas_alu_dispatch.sv
// Bench for mas_alu_dispatch: registered model units, a transaction-level model with a
// per-cycle compare, directed scenarios with literal expectations, and an FU_LAT=3 instance.
`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

module tb_mas_alu_dispatch;
  import mas_alu_pkg::*;

  localparam int BLEN   = `MAS_BLEN;
  localparam int NUM_FU = MAS_NUM_FU;
  localparam int LAT    = 1;
  localparam int LAT3   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mas_alu_dispatch_if #(.BLEN(BLEN), .NUM_FU(NUM_FU)) bus ();
  mas_alu_dispatch_if #(.BLEN(BLEN), .NUM_FU(NUM_FU)) bus3 ();

  mas_alu_dispatch #(.BLEN(BLEN), .NUM_FU(NUM_FU), .FU_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mas_alu_dispatch #(.BLEN(BLEN), .NUM_FU(NUM_FU), .FU_LAT(LAT3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BLEN-1:0] op_result(input int opc, input logic [BLEN-1:0] a,
                                                input logic [BLEN-1:0] b);
    case (opc)
      0:       return a + b;
      1:       return a - b;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      5:       return a << b;
      6:       return a >> b;
      default: return '0;
    endcase
  endfunction

  // Registered functional units (one edge of latency) on both operand buses.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      bus.fu_res[i*BLEN +: BLEN]  <= op_result(i, bus.fu_op1, bus.fu_op2);
      bus3.fu_res[i*BLEN +: BLEN] <= op_result(i, bus3.fu_op1, bus3.fu_op2);
    end
  end

  // Transaction-level model: an op is either pending (with its age in edges) or answered.
  bit              m_busy = 1'b0;
  int              m_age  = 0;
  int              m_opc  = 0;
  logic [BLEN-1:0] m_a    = '0;
  logic [BLEN-1:0] m_b    = '0;
  bit              m_rv   = 1'b0;
  bit              m_err  = 1'b0;
  logic [BLEN-1:0] m_data = '0;
  logic [BLEN-1:0] m_fu1  = '0;
  logic [BLEN-1:0] m_fu2  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_rv   <= 1'b0;
      m_err  <= 1'b0;
      m_data <= '0;
      m_fu1  <= '0;
      m_fu2  <= '0;
    end else if (m_rv) begin
      if (bus.resp_ready) begin
        m_rv  <= 1'b0;
        m_err <= 1'b0;
      end
    end else if (m_busy) begin
      m_age <= m_age + 1;
      // Result is due on edge FU_LAT+1 after accept, or later if the unit is not ready.
      if (m_age + 1 > LAT && bus.fu_ready[m_opc]) begin
        m_data <= op_result(m_opc, m_a, m_b);
        m_err  <= 1'b0;
        m_rv   <= 1'b1;
        m_busy <= 1'b0;
      end
    end else if (bus.req_valid) begin
      if (int'(bus.req_opc) < NUM_FU) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_opc  <= int'(bus.req_opc);
        m_a    <= bus.req_op1;
        m_b    <= bus.req_op2;
        m_fu1  <= bus.req_op1;
        m_fu2  <= bus.req_op2;
      end else begin
        m_data <= '0;
        m_err  <= 1'b1;
        m_rv   <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_req_ready", bus.req_ready, !m_busy && !m_rv);
      check("cmp_resp_valid", bus.resp_valid, m_rv);
      check("cmp_resp_err", bus.resp_err, m_err);
      check("cmp_resp_data", bus.resp_data, m_data);
      check("cmp_fu_op1", bus.fu_op1, m_fu1);
      check("cmp_fu_op2", bus.fu_op2, m_fu2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [2:0] opc, input logic [BLEN-1:0] a, input logic [BLEN-1:0] b);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_opc   = opc;
    bus.req_op1   = a;
    bus.req_op2   = b;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int max_cycles);
    int n = 0;
    while (!bus.resp_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_resp_valid", bus.resp_valid, 1);
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_opc     = '0;
    bus.req_op1     = '0;
    bus.req_op2     = '0;
    bus.resp_ready  = 1'b0;
    bus.fu_ready    = '1;
    bus3.req_valid  = 1'b0;
    bus3.req_opc    = '0;
    bus3.req_op1    = '0;
    bus3.req_op2    = '0;
    bus3.resp_ready = 1'b0;
    bus3.fu_ready   = '1;

    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_fu_op1", bus.fu_op1, 0);
    check("rst_fu_op2", bus.fu_op2, 0);
    rst    = 1'b0;
    chk_en = 1'b1;
    tick();

    // SRL 0xF0 >> 4
    send(3'd6, 'h000000F0, 'd4);
    check("srl_e0_fu_op1", bus.fu_op1, 'hF0);
    check("srl_e0_valid", bus.resp_valid, 0);
    tick();
    check("srl_e1_valid", bus.resp_valid, 0);
    tick();
    check("srl_e2_valid", bus.resp_valid, 1);
    check("srl_e2_data", bus.resp_data, 'h0000000F);
    check("srl_e2_err", bus.resp_err, 0);
    check("srl_e2_req_ready", bus.req_ready, 0);
    tick();
    check("srl_hold_fu_op1", bus.fu_op1, 'hF0);
    check("srl_hold_valid", bus.resp_valid, 1);
    handshake();
    check("srl_post_req_ready", bus.req_ready, 1);

    // Backpressure: ADD 5+7, consumer stalls 5 cycles, stray request in the window
    send(3'd0, 'd5, 'd7);
    wait_resp(10);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", bus.resp_data, 'd12);
      check("bp_valid", bus.resp_valid, 1);
      check("bp_req_ready", bus.req_ready, 0);
      if (i == 2) begin
        bus.req_valid = 1'b1;
        bus.req_opc   = 3'd1;
        bus.req_op1   = 'd100;
        bus.req_op2   = 'd1;
      end else begin
        bus.req_valid = 1'b0;
      end
      tick();
    end
    bus.req_valid = 1'b0;
    handshake();
    check("bp_post_req_ready", bus.req_ready, 1);
    check("bp_post_valid", bus.resp_valid, 0);
    check("bp_post_fu_op1", bus.fu_op1, 'd5);

    // Illegal opcode 7
    send(3'd7, 'hFFFF, 'd0);
    check("ill_valid", bus.resp_valid, 1);
    check("ill_err", bus.resp_err, 1);
    check("ill_data", bus.resp_data, 0);
    check("ill_fu_op1", bus.fu_op1, 'd5);
    check("ill_fu_op2", bus.fu_op2, 'd7);
    handshake();
    check("ill_post_err", bus.resp_err, 0);

    // Unit not ready: SLL 1<<3 with unit 5 stalled for 4 cycles
    bus.fu_ready[5] = 1'b0;
    send(3'd5, 'd1, 'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nr_wait_valid", bus.resp_valid, 0);
    end
    bus.fu_ready[5] = 1'b1;
    check("nr_rise_valid", bus.resp_valid, 0);
    tick();
    check("nr_cap_valid", bus.resp_valid, 1);
    check("nr_cap_data", bus.resp_data, 'd8);
    handshake();

    // Reset in the middle of WAIT drops the op
    send(3'd1, 'd9, 'd4);
    tick();
    rst = 1'b1;
    #1;
    check("mr_req_ready", bus.req_ready, 1);
    check("mr_resp_valid", bus.resp_valid, 0);
    check("mr_fu_op1", bus.fu_op1, 0);
    check("mr_fu_op2", bus.fu_op2, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mr_no_resp", bus.resp_valid, 0);
    end
    send(3'd1, 'd9, 'd4);
    wait_resp(10);
    check("mr_recover_data", bus.resp_data, 'd5);
    handshake();

    // FU_LAT=3 instance: XOR 0xA5 ^ 0x0F
    check("lat3_req_ready", bus3.req_ready, 1);
    bus3.req_valid = 1'b1;
    bus3.req_opc   = 3'd4;
    bus3.req_op1   = 'hA5;
    bus3.req_op2   = 'h0F;
    tick();
    bus3.req_valid = 1'b0;
    tick();
    check("lat3_e1_valid", bus3.resp_valid, 0);
    tick();
    check("lat3_e2_valid", bus3.resp_valid, 0);
    tick();
    check("lat3_e3_valid", bus3.resp_valid, 0);
    tick();
    check("lat3_e4_valid", bus3.resp_valid, 1);
    check("lat3_e4_data", bus3.resp_data, 'hAA);
    check("lat3_e4_err", bus3.resp_err, 0);
    bus3.resp_ready = 1'b1;
    tick();
    bus3.resp_ready = 1'b0;
    check("lat3_post_req_ready", bus3.req_ready, 1);

    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
